// File: rtl/ws2812_decoder_if.sv
// Decoded-word output bundle of the WS2812B receiver.
// master: the decoder that drives it; slave: the consumer.
interface ws2812_decoder_if;
  logic [23:0] word;
  logic        word_valid;
  logic [7:0]  word_count;
  logic        frame_done;
  logic        bit_err;

  modport master (
    output word,
    output word_valid,
    output word_count,
    output frame_done,
    output bit_err
  );

  modport slave (
    input word,
    input word_valid,
    input word_count,
    input frame_done,
    input bit_err
  );
endinterface

// File: rtl/ws2812_decoder.sv
// WS2812B receiver: recovers 24-bit words from high-pulse widths, flags frame end on a low gap.
// Optional malformed-pulse detection is enabled by defining PULSE_CHECK_EN.
module ws2812_decoder #(
  parameter int unsigned T1_MIN_CYC = 24,
  parameter int unsigned RESET_CYC  = 2000,
  parameter int unsigned T_MIN_CYC  = 8,
  parameter int unsigned T_MAX_CYC  = 60,
  parameter int unsigned CNT_W      = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              din,
  ws2812_decoder_if.master  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] T1_LIM  = CNT_W'(T1_MIN_CYC);
  // The cycle that reaches this count is the RESET_CYC-th consecutive low cycle.
  localparam logic [CNT_W-1:0] RST_LIM = CNT_W'(RESET_CYC - 1);

  generate
    if (T_MIN_CYC > T_MAX_CYC || RESET_CYC < 2 || RESET_CYC > (2 ** CNT_W) - 1) begin : g_cfg_err
      $error("ws2812_decoder: inconsistent timing parameters");
    end
  endgenerate

  logic             sync1;
  logic             ds;
  logic             ds_q;
  logic             rise;
  logic             fall;

  logic [1:0]       state;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic [4:0]       bitcnt;
  logic [22:0]      sreg;
  logic [23:0]      word_r;
  logic             valid_r;
  logic [7:0]       count_r;
  logic             fdone_r;
  logic             berr_r;

  logic             bit_val;
  logic             pulse_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      ds    <= 1'b0;
      ds_q  <= 1'b0;
    end else begin
      sync1 <= din;
      ds    <= sync1;
      ds_q  <= ds;
    end
  end

  assign rise    = ds & ~ds_q;
  assign fall    = ~ds & ds_q;
  assign bit_val = (hcnt >= T1_LIM);

`ifdef PULSE_CHECK_EN
  assign pulse_bad = (hcnt < CNT_W'(T_MIN_CYC)) || (hcnt > CNT_W'(T_MAX_CYC));
`else
  assign pulse_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      hcnt    <= '0;
      lcnt    <= '0;
      bitcnt  <= '0;
      sreg    <= '0;
      word_r  <= '0;
      valid_r <= 1'b0;
      count_r <= '0;
      fdone_r <= 1'b0;
      berr_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      fdone_r <= 1'b0;
      berr_r  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_HIGH;
            hcnt  <= CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_LOW;
            lcnt  <= CNT_ONE;
            if (pulse_bad) begin
              berr_r <= 1'b1;
              bitcnt <= '0;
            end else if (bitcnt == 5'd23) begin
              word_r  <= {bit_val, sreg};
              valid_r <= 1'b1;
              bitcnt  <= '0;
              if (count_r != 8'hFF) begin
                count_r <= count_r + 8'd1;
              end
            end else begin
              sreg[bitcnt] <= bit_val;
              bitcnt       <= bitcnt + 5'd1;
            end
          end else if (hcnt != CNT_MAX) begin
            hcnt <= hcnt + CNT_ONE;
          end
        end
        ST_LOW: begin
          // A rising edge takes priority over a gap completing in the same cycle.
          if (rise) begin
            state <= ST_HIGH;
            hcnt  <= CNT_ONE;
          end else if (lcnt >= RST_LIM) begin
            state   <= ST_IDLE;
            fdone_r <= (bitcnt != 5'd0) || (count_r != 8'd0);
            bitcnt  <= '0;
            count_r <= '0;
          end else begin
            lcnt <= lcnt + CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.word       = word_r;
  assign bus.word_valid = valid_r;
  assign bus.word_count = count_r;
  assign bus.frame_done = fdone_r;
  assign bus.bit_err    = berr_r;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder with a scoreboard of expected words.
`timescale 1ns/1ps
module tb_ws2812_decoder;

  logic clk;
  logic reset_n;
  logic din;

  ws2812_decoder_if dbus ();

  ws2812_decoder #(
    .T1_MIN_CYC(24),
    .RESET_CYC (2000),
    .T_MIN_CYC (8),
    .T_MAX_CYC (60),
    .CNT_W     (12)
  ) u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (din),
    .bus    (dbus)
  );

  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int fd_count = 0;
  int be_count = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (dbus.word_valid === 1'b1) begin
        vcount++;
        if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else check("word", {8'h0, dbus.word}, {8'h0, exp_q.pop_front()});
      end
      if (dbus.frame_done === 1'b1) fd_count++;
      if (dbus.bit_err === 1'b1) be_count++;
    end
  end

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int h0, input int h1, input int l0, input int l1);
    if (b) begin drive(1'b1, h1); drive(1'b0, l1); end
    else   begin drive(1'b1, h0); drive(1'b0, l0); end
  endtask

  task automatic send_word(input logic [23:0] w, input bit lat);
    logic [23:0] v;
    v = w;
    exp_q.push_back(w);
    for (int i = 0; i < 24; i++) begin
      if (lat && i == 23) begin
        drive(1'b1, v[i] ? 33 : 17);
        din = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("lat_edge2", {31'h0, dbus.word_valid}, 32'd0);
        @(posedge clk);
        #1 check("lat_edge3", {31'h0, dbus.word_valid}, 32'd1);
        check("lat_word", {8'h0, dbus.word}, {8'h0, w});
        repeat ((v[i] ? 19 : 35) - 3) @(posedge clk);
        #1;
      end else begin
        send_bit(v[i], 17, 33, 35, 19);
      end
    end
  endtask

  task automatic wait_valid(input string tag, input int target);
    int n;
    n = 0;
    while (vcount < target && n < 200) begin @(posedge clk); n++; end
    #1 check(tag, vcount, target);
  endtask

  task automatic wait_fd(input string tag, input int target);
    int n;
    n = 0;
    while (fd_count < target && n < 300) begin @(posedge clk); n++; end
    #1 check(tag, fd_count, target);
  endtask

  initial begin
    logic [23:0] w;
    logic [23:0] p;
    int v0;
    din = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word", {8'h0, dbus.word}, 32'h0);
    check("rst_valid", {31'h0, dbus.word_valid}, 32'h0);
    check("rst_count", {24'h0, dbus.word_count}, 32'h0);
    check("rst_fdone", {31'h0, dbus.frame_done}, 32'h0);
    check("rst_berr", {31'h0, dbus.bit_err}, 32'h0);
    reset_n = 1'b1;
    drive(1'b0, 5);

    // single word with latency check, then frame end
    send_word(24'h00b000, 1'b1);
    wait_valid("one_word_valid", 1);
    check("one_word_count", {24'h0, dbus.word_count}, 32'd1);
    drive(1'b0, 1980);
    wait_fd("one_word_fd", 1);
    check("one_word_count_clr", {24'h0, dbus.word_count}, 32'd0);
    check("word_hold", {8'h0, dbus.word}, 32'h00b000);

    // nine back-to-back words
    v0 = vcount;
    for (int k = 0; k < 9; k++) begin
      w = 24'($urandom);
      send_word(w, 1'b0);
    end
    wait_valid("nine_valid", v0 + 9);
    check("nine_count", {24'h0, dbus.word_count}, 32'd9);
    drive(1'b0, 1990);
    wait_fd("nine_fd", 2);
    check("nine_count_clr", {24'h0, dbus.word_count}, 32'd0);

    // partial frame of 12 bits
    v0 = vcount;
    p = 24'hfa5a5a;
    for (int i = 0; i < 12; i++) send_bit(p[i], 17, 33, 35, 19);
    drive(1'b0, 1990);
    wait_fd("partial_fd", 3);
    check("partial_no_valid", vcount, v0);
    send_word(24'h5a3c96, 1'b0);
    wait_valid("after_partial", v0 + 1);
    drive(1'b0, 1990);
    wait_fd("after_partial_fd", 4);

    // threshold: zeros at 23 cycles high, ones at 24
    v0 = vcount;
    w = 24'h3c5a69;
    exp_q.push_back(w);
    for (int i = 0; i < 24; i++) send_bit(w[i], 23, 24, 30, 30);
    wait_valid("threshold", v0 + 1);
    check("threshold_word", {8'h0, dbus.word}, 32'h3c5a69);

`ifndef PULSE_CHECK_EN
    // stuck-high first bit saturates and decodes as 1
    v0 = vcount;
    w = 24'h000a01;
    exp_q.push_back(w);
    drive(1'b1, 5000);
    drive(1'b0, 30);
    for (int i = 1; i < 24; i++) send_bit(w[i], 17, 33, 35, 19);
    wait_valid("stuck_high", v0 + 1);
    check("stuck_word", {8'h0, dbus.word}, 32'h000a01);
`endif
    drive(1'b0, 2010);

    // reset mid-word
    v0 = vcount;
    p = 24'hffffff;
    for (int i = 0; i < 10; i++) send_bit(p[i], 17, 33, 35, 19);
    drive(1'b1, 10);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_word", {8'h0, dbus.word}, 32'h0);
    check("midrst_count", {24'h0, dbus.word_count}, 32'h0);
    check("midrst_valid", {31'h0, dbus.word_valid}, 32'h0);
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(1'b0, 5);
    check("midrst_no_valid", vcount, v0);
    send_word(24'h909090, 1'b0);
    wait_valid("midrst_recover", v0 + 1);
    check("midrst_recover_word", {8'h0, dbus.word}, 32'h909090);

`ifdef PULSE_CHECK_EN
    // short glitch aborts the word in progress
    v0 = vcount;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 17, 33, 35, 19);
    drive(1'b1, 4);
    drive(1'b0, 30);
    check("glitch_berr", be_count, 1);
    for (int i = 0; i < 19; i++) send_bit(1'b0, 17, 33, 35, 19);
    check("glitch_no_valid", vcount, v0);
    drive(1'b0, 2010);
    send_word(24'h123456, 1'b0);
    wait_valid("glitch_recover", v0 + 1);
`else
    check("no_berr", be_count, 0);
`endif

    drive(1'b0, 50);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
